// File: rtl/parking_lot_multi_if.sv
// Sensor-side and status-side signals of the multi-gate parking lot detector.
// master drives the sensors and flag clear; slave is the detector itself.
interface parking_lot_multi_if #(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned OCC_W     = 4
);
  logic [NUM_GATES-1:0] a;
  logic [NUM_GATES-1:0] b;
  logic                 clr_flags;
  logic [NUM_GATES-1:0] entering;
  logic [NUM_GATES-1:0] exiting;
  logic [OCC_W-1:0]     occupancy;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output a, b, clr_flags,
    input  entering, exiting, occupancy, full, empty, overflow, underflow
  );

  modport slave (
    input  a, b, clr_flags,
    output entering, exiting, occupancy, full, empty, overflow, underflow
  );
endinterface

// File: rtl/parking_lot_multi.sv
// Multi-gate parking lot detector: per-gate direction FSMs feeding a shared saturating
// occupancy counter. Optional sensor synchronizer/debounce enabled by SENSOR_DEBOUNCE_EN.
module parking_lot_multi #(
  parameter int unsigned NUM_GATES  = 2,
  parameter int unsigned CAPACITY   = 15,
  parameter int unsigned OCC_W      = 4,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_lot_multi_if.slave    bus
);

  localparam int unsigned SUM_W = OCC_W + 4;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  state_t                  state_q [NUM_GATES];
  state_t                  state_d [NUM_GATES];
  logic [NUM_GATES-1:0]    a_f;
  logic [NUM_GATES-1:0]    b_f;
  logic [NUM_GATES-1:0]    ent_c;
  logic [NUM_GATES-1:0]    ext_c;
  logic [NUM_GATES-1:0]    ent_q;
  logic [NUM_GATES-1:0]    ext_q;
  logic [OCC_W-1:0]        occ_q;
  logic                    ovf_q;
  logic                    unf_q;
  logic signed [SUM_W-1:0] sum_c;
  logic                    sum_neg_c;

`ifdef SENSOR_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic [2*NUM_GATES-1:0] raw_c;
  logic [2*NUM_GATES-1:0] sync1_q;
  logic [2*NUM_GATES-1:0] sync2_q;
  logic [2*NUM_GATES-1:0] filt_q;
  logic [CNT_W-1:0]       cnt_q [2*NUM_GATES];

  assign raw_c = {bus.a, bus.b};

  // Two-flop synchronizer, then each bit must differ from the filtered value for DEB_CYCLES clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < 2*NUM_GATES; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2*NUM_GATES; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign a_f = filt_q[2*NUM_GATES-1:NUM_GATES];
  assign b_f = filt_q[NUM_GATES-1:0];
`else
  logic unused_deb_c;
  assign unused_deb_c = ^(32'(DEB_CYCLES));
  assign a_f = bus.a;
  assign b_f = bus.b;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NUM_GATES; g++) state_q[g] <= IDLE;
    end else begin
      for (int g = 0; g < NUM_GATES; g++) state_q[g] <= state_d[g];
    end
  end

  // Per-gate direction decode; a completion fires only when the pattern finishes on ab=00
  always_comb begin
    logic [1:0] ab;
    ab    = 2'b00;
    ent_c = '0;
    ext_c = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      state_d[g] = state_q[g];
      ab         = {a_f[g], b_f[g]};
      case (state_q[g])
        IDLE: begin
          if (ab == 2'b10)      state_d[g] = EN1;
          else if (ab == 2'b01) state_d[g] = EX1;
        end
        EN1: begin
          if (ab == 2'b11)      state_d[g] = EN2;
          else if (ab != 2'b10) state_d[g] = IDLE;
        end
        EN2: begin
          if (ab == 2'b01)      state_d[g] = EN3;
          else if (ab == 2'b10) state_d[g] = EN1;
          else if (ab == 2'b00) state_d[g] = IDLE;
        end
        EN3: begin
          if (ab == 2'b00) begin
            state_d[g] = IDLE;
            ent_c[g]   = 1'b1;
          end else if (ab == 2'b11) begin
            state_d[g] = EN2;
          end else if (ab == 2'b10) begin
            state_d[g] = IDLE;
          end
        end
        EX1: begin
          if (ab == 2'b11)      state_d[g] = EX2;
          else if (ab != 2'b01) state_d[g] = IDLE;
        end
        EX2: begin
          if (ab == 2'b10)      state_d[g] = EX3;
          else if (ab == 2'b01) state_d[g] = EX1;
          else if (ab == 2'b00) state_d[g] = IDLE;
        end
        EX3: begin
          if (ab == 2'b00) begin
            state_d[g] = IDLE;
            ext_c[g]   = 1'b1;
          end else if (ab == 2'b11) begin
            state_d[g] = EX2;
          end else if (ab == 2'b01) begin
            state_d[g] = IDLE;
          end
        end
        default: state_d[g] = IDLE;
      endcase
    end
  end

  // Net all simultaneous events first, then clamp
  always_comb begin
    sum_c = $signed({4'b0000, occ_q})
          + SUM_W'($countones(ent_c))
          - SUM_W'($countones(ext_c));
    sum_neg_c = sum_c[SUM_W-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      ext_q <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ent_q <= ent_c;
      ext_q <= ext_c;
      if (sum_c > CAP_S)  occ_q <= OCC_W'(CAPACITY);
      else if (sum_neg_c) occ_q <= '0;
      else                occ_q <= sum_c[OCC_W-1:0];
      // A new error in the same cycle beats a clear request
      if (sum_c > CAP_S)       ovf_q <= 1'b1;
      else if (bus.clr_flags)  ovf_q <= 1'b0;
      if (sum_neg_c)           unf_q <= 1'b1;
      else if (bus.clr_flags)  unf_q <= 1'b0;
    end
  end

  assign bus.entering  = ent_q;
  assign bus.exiting   = ext_q;
  assign bus.occupancy = occ_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.full      = (occ_q == OCC_W'(CAPACITY));
  assign bus.empty     = (occ_q == '0);

endmodule

// File: tb/tb_parking_lot_multi.sv
// Self-checking bench for parking_lot_multi: pattern-position model checked every cycle,
// plus literal checkpoints on occupancy, flags and pulse counts.
module tb_parking_lot_multi;

  localparam int unsigned NG  = 2;
  localparam int unsigned CAP = 15;
  localparam int unsigned OW  = 4;
  localparam int unsigned DEB = 4;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int STEP = 8;
  localparam int LAT  = 2 + DEB;
`else
  localparam int STEP = 2;
  localparam int LAT  = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_lot_multi_if #(.NUM_GATES(NG), .OCC_W(OW)) bus ();

  parking_lot_multi #(
    .NUM_GATES(NG), .CAPACITY(CAP), .OCC_W(OW), .DEB_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each gate tracks a direction and how far along its 3-step pattern it is
  int          m_dir [NG];
  int          m_pos [NG];
  int          m_occ;
  bit          m_ovf, m_unf;
  bit [NG-1:0] m_ent, m_ext;
  bit [NG-1:0] ea, eb;
  int          q, s;
`ifdef SENSOR_DEBOUNCE_EN
  bit [2*NG-1:0] hist [DEB+2];
  bit [2*NG-1:0] filt;
  bit            steady;
`endif

  function automatic int pos_of(input int dir, input logic [1:0] ab);
    if (dir > 0) begin
      case (ab)
        2'b10: return 1;
        2'b11: return 2;
        2'b01: return 3;
        default: return 0;
      endcase
    end
    case (ab)
      2'b01: return 1;
      2'b11: return 2;
      2'b10: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NG; g++) begin
        m_dir[g] = 0;
        m_pos[g] = 0;
      end
      m_occ = 0; m_ovf = 0; m_unf = 0; m_ent = '0; m_ext = '0;
`ifdef SENSOR_DEBOUNCE_EN
      for (int i = 0; i < DEB + 2; i++) hist[i] = '0;
      filt = '0;
`endif
    end else begin
`ifdef SENSOR_DEBOUNCE_EN
      ea = filt[2*NG-1:NG];
      eb = filt[NG-1:0];
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {bus.a, bus.b};
      // a bit flips once its synchronized copy has held the other value DEB clocks
      for (int k = 0; k < 2*NG; k++) begin
        steady = 1'b1;
        for (int i = 2; i <= DEB + 1; i++) if (hist[i][k] == filt[k]) steady = 1'b0;
        if (steady) filt[k] = ~filt[k];
      end
`else
      ea = bus.a;
      eb = bus.b;
`endif
      m_ent = '0;
      m_ext = '0;
      for (int g = 0; g < NG; g++) begin
        if (m_dir[g] == 0) begin
          if ({ea[g], eb[g]} == 2'b10)      begin m_dir[g] = 1;  m_pos[g] = 1; end
          else if ({ea[g], eb[g]} == 2'b01) begin m_dir[g] = -1; m_pos[g] = 1; end
        end else begin
          q = pos_of(m_dir[g], {ea[g], eb[g]});
          if (q == 0) begin
            if (m_pos[g] == 3) begin
              if (m_dir[g] > 0) m_ent[g] = 1'b1;
              else              m_ext[g] = 1'b1;
            end
            m_dir[g] = 0;
          end else if (q == m_pos[g] + 1 || q == m_pos[g] - 1) begin
            m_pos[g] = q;
          end else if (q != m_pos[g]) begin
            m_dir[g] = 0;
          end
        end
      end
      s = m_occ + $countones(m_ent) - $countones(m_ext);
      if (s > int'(CAP)) m_ovf = 1'b1; else if (bus.clr_flags) m_ovf = 1'b0;
      if (s < 0)         m_unf = 1'b1; else if (bus.clr_flags) m_unf = 1'b0;
      m_occ = (s > int'(CAP)) ? int'(CAP) : (s < 0) ? 0 : s;
    end
  end

  int ent_seen [NG];
  int ext_seen [NG];

  // Every-cycle comparison against the model, plus pulse tallies for literal checks
  always @(negedge clk) begin
    if (reset) begin
      chk("entering",  int'(bus.entering),  int'(m_ent));
      chk("exiting",   int'(bus.exiting),   int'(m_ext));
      chk("occupancy", int'(bus.occupancy), m_occ);
      chk("full",      int'(bus.full),      int'(m_occ == int'(CAP)));
      chk("empty",     int'(bus.empty),     int'(m_occ == 0));
      chk("overflow",  int'(bus.overflow),  int'(m_ovf));
      chk("underflow", int'(bus.underflow), int'(m_unf));
      for (int g = 0; g < NG; g++) begin
        if (bus.entering[g]) ent_seen[g]++;
        if (bus.exiting[g])  ext_seen[g]++;
      end
    end
  end

  task automatic step(input logic [1:0] ab0, input logic [1:0] ab1);
    bus.a = {ab1[1], ab0[1]};
    bus.b = {ab1[0], ab0[0]};
    repeat (STEP) @(negedge clk);
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic entry0();
    step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00); step(2'b00, 2'b00);
  endtask

  task automatic exit1();
    step(2'b00, 2'b01); step(2'b00, 2'b11); step(2'b00, 2'b10); step(2'b00, 2'b00);
  endtask

  initial begin
    for (int g = 0; g < NG; g++) begin
      ent_seen[g] = 0;
      ext_seen[g] = 0;
    end
    bus.a = '0; bus.b = '0; bus.clr_flags = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_occupancy", int'(bus.occupancy), 0);
    chk("rst_empty",     int'(bus.empty),     1);
    chk("rst_full",      int'(bus.full),      0);
    chk("rst_pulses",    int'({bus.entering, bus.exiting}), 0);
    chk("rst_flags",     int'({bus.overflow, bus.underflow}), 0);
    reset = 1'b1;

    // gate 0 entry then exit
    step(2'b00, 2'b00); entry0(); settle();
    chk("g0_entry_occ",   int'(bus.occupancy), 1);
    chk("g0_entry_count", ent_seen[0], 1);
    chk("model_occ_1",    m_occ, 1);
    step(2'b00, 2'b00); step(2'b01, 2'b00); step(2'b11, 2'b00); step(2'b10, 2'b00);
    step(2'b00, 2'b00); settle();
    chk("g0_exit_occ",   int'(bus.occupancy), 0);
    chk("g0_exit_count", ext_seen[0], 1);

    // gate 1 abort, then reversal ending in one entry
    step(2'b00, 2'b10); step(2'b00, 2'b11); step(2'b00, 2'b10); step(2'b00, 2'b00); settle();
    chk("g1_abort_occ",   int'(bus.occupancy), 0);
    chk("g1_abort_count", ent_seen[1], 0);
    step(2'b00, 2'b10); step(2'b00, 2'b11); step(2'b00, 2'b01);
    step(2'b00, 2'b11); step(2'b00, 2'b01); step(2'b00, 2'b00); settle();
    chk("g1_rev_occ",   int'(bus.occupancy), 1);
    chk("g1_rev_count", ent_seen[1], 1);

    // simultaneous entries, then entry on gate 0 against exit on gate 1
    step(2'b10, 2'b10); step(2'b11, 2'b11); step(2'b01, 2'b01); step(2'b00, 2'b00); settle();
    chk("both_entry_occ", int'(bus.occupancy), 3);
    step(2'b10, 2'b01); step(2'b11, 2'b11); step(2'b01, 2'b10); step(2'b00, 2'b00); settle();
    chk("net_zero_occ",   int'(bus.occupancy), 3);
    chk("net_zero_exits", ext_seen[1], 1);
    chk("model_occ_3",    m_occ, 3);

    // saturate high
    for (int i = 0; i < 16; i++) entry0();
    settle();
    chk("sat_occ",  int'(bus.occupancy), 15);
    chk("sat_full", int'(bus.full),      1);
    chk("sat_ovf",  int'(bus.overflow),  1);

    // drain below zero
    for (int i = 0; i < 16; i++) exit1();
    settle();
    chk("drain_occ",   int'(bus.occupancy), 0);
    chk("drain_empty", int'(bus.empty),     1);
    chk("drain_unf",   int'(bus.underflow), 1);
    chk("drain_ovf",   int'(bus.overflow),  1);

    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    settle();
    chk("clr_ovf", int'(bus.overflow),  0);
    chk("clr_unf", int'(bus.underflow), 0);

    // reset in mid-sequence discards the partial entry
    step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00); settle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(2'b00, 2'b00); settle();
    chk("midrst_count", ent_seen[0], 19);
    chk("midrst_occ",   int'(bus.occupancy), 0);

`ifdef SENSOR_DEBOUNCE_EN
    // short glitch on a[0] must not start a sequence
    bus.a = 2'b01;
    repeat (2) @(negedge clk);
    bus.a = 2'b00;
    repeat (LAT + 4) @(negedge clk);
    step(2'b01, 2'b00); step(2'b00, 2'b00); settle();
    chk("glitch_count", ent_seen[0], 19);
    entry0(); settle();
    chk("deb_entry_occ", int'(bus.occupancy), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_lot_multi.md
Name: parking_lot_multi

Overview:
- Multi-gate successor to the single-gate parking lot detector. Each of NUM_GATES gates has an outer sensor (a) and an inner sensor (b), and each gate runs its own direction-decoding FSM.
- Per-gate entering/exiting pulses feed a shared, saturating occupancy counter. The counter drives full/empty status and sticky overflow/underflow error flags.
- Sits between the raw gate sensor inputs and the lot display/barrier controller.

Parameters:
- NUM_GATES, 2, number of independent gates (1..8).
- CAPACITY, 15, maximum occupancy (1..255).
- OCC_W, 4, width of the occupancy output; must equal $clog2(CAPACITY+1).
- DEB_CYCLES, 4, debounce stability length in clocks (>=2); used only with SENSOR_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a  input  NUM_GATES  outer sensor per gate; bit g = gate g; 1 = beam blocked.
- b  input  NUM_GATES  inner sensor per gate; 1 = beam blocked.
- clr_flags  input  1  synchronous clear of the overflow and underflow flags.
- entering  output  NUM_GATES  one-cycle pulse per gate on a completed entry.
- exiting  output  NUM_GATES  one-cycle pulse per gate on a completed exit.
- occupancy  output  OCC_W  current car count.
- full  output  1  high when occupancy == CAPACITY.
- empty  output  1  high when occupancy == 0.
- overflow  output  1  sticky; an entry was seen at CAPACITY.
- underflow  output  1  sticky; an exit was seen at 0.

Behaviour:
- Reset (reset=0, asynchronous): all FSMs go to IDLE. entering=0, exiting=0, occupancy=0, overflow=0, underflow=0, empty=1, full=0.
- Sensor pair notation: ab = {a[g], b[g]}, sampled each rising edge.
- Per-gate FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
  - From IDLE: ab=10 -> EN1; ab=01 -> EX1; ab=00 or 11 -> stay in IDLE.
  - EN1: 11 -> EN2; 00 -> IDLE (car backed out); 10 -> hold; 01 -> IDLE.
  - EN2: 01 -> EN3; 10 -> EN1 (reversal); 11 -> hold; 00 -> IDLE.
  - EN3: 00 -> IDLE and set entering[g]; 11 -> EN2; 01 -> hold; 10 -> IDLE.
  - EX1/EX2/EX3 mirror EN1/EN2/EN3 with a and b swapped. The transition EX3 -> IDLE on ab=00 sets exiting[g].
- Pulse timing: entering/exiting are registered. They are high for exactly one cycle, starting at the edge that samples the final ab=00. Latency is 1 clock from the sensor sample, plus the debounce delay when enabled.
- Counter:
  - Same edge as the pulses: sum = occupancy + popcount(entry events) − popcount(exit events), evaluated at OCC_W+4 signed width.
  - occupancy <= clamp(sum, 0, CAPACITY).
  - Simultaneous entries/exits on any gates are netted first, then clamped. Example: one entry and one exit at full gives occupancy unchanged and no overflow.
- Error flags:
  - overflow <= 1 when sum > CAPACITY; underflow <= 1 when sum < 0.
  - clr_flags=1 clears both flags on the next edge. If a new error occurs in the same cycle, set wins over clear.
- full and empty are decoded directly from the occupancy register (no additional latency).
- Gates are fully independent. No cross-gate interaction exists except at the counter.
- If reset is asserted mid-sequence, the partial sequence is discarded and no pulse is emitted.

Optional Feature:
- Macro: SENSOR_DEBOUNCE_EN.
- Defined: each a/b bit passes through a 2-flop synchronizer, then a stability counter. The filtered value updates only after the synchronized input has been constant for DEB_CYCLES consecutive clocks. Glitches shorter than DEB_CYCLES are ignored. Added latency is 2+DEB_CYCLES clocks. The filters reset to 0.
- Undefined: raw a/b feed the FSMs directly, with no synchronizer and no filter.

Test Plan:
- Reset: hold reset=0 for 2 clocks, then release -> occupancy=0, empty=1, full=0, all pulses 0, flags 0.
- Gate 0 entry, 2 clocks per step: ab = 00, 10, 11, 01, 00 -> entering[0] high for exactly 1 cycle, occupancy 0->1. Then exit sequence 00, 01, 11, 10, 00 -> exiting[0] pulse, occupancy 1->0.
- Aborts and reversals: gate 1 ab = 10, 11, 10, 00 -> no pulse, occupancy unchanged. Then ab = 10, 11, 01, 11, 01, 00 -> exactly one entering[1] pulse.
- Simultaneous events (NUM_GATES=2): completed entries on both gates in the same cycle -> occupancy +2. Completed entry on gate 0 and exit on gate 1 in the same cycle -> occupancy unchanged.
- Saturation (CAPACITY=15): 16 entries -> occupancy holds at 15, full=1, overflow=1. Then exits with occupancy at 0 -> occupancy=0, underflow=1. Pulse clr_flags -> both flags 0.
- With SENSOR_DEBOUNCE_EN, DEB_CYCLES=4: a 2-cycle glitch a[0]=1 from IDLE -> no state change. A full entry sequence with 8-cycle steps -> entering[0] pulse delayed by 6 clocks relative to the non-debounced build.
